// File: rtl/mc_sync_fifo.sv
// Single-clock multi-channel FIFO: NUM_CH logical queues share one storage array.
// Optional macro MC_FIFO_ERR_STICKY_EN makes OVF/UDF sticky until ERR_CLR or RST.
module mc_sync_fifo #(
  parameter int addr_width = 4,
  parameter int data_width = 9,
  parameter int NUM_CH     = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_EN,
  input  logic [CH_W-1:0]       W_CH,
  input  logic [data_width-1:0] W_DATA,
  input  logic                  R_EN,
  input  logic [CH_W-1:0]       R_CH,
  output logic [data_width-1:0] R_DATA,
  output logic                  R_VALID,
  output logic [NUM_CH-1:0]     FULL,
  output logic [NUM_CH-1:0]     EMPTY,
  output logic [NUM_CH-1:0]     ALMOST_FULL,
  output logic [NUM_CH-1:0]     ALMOST_EMPTY,
  output logic [NUM_CH-1:0]     OVF,
  output logic [NUM_CH-1:0]     UDF,
  input  logic [NUM_CH-1:0]     ERR_CLR
);

  localparam int DEPTH = 2 ** addr_width;
  localparam int PW    = addr_width + 1;
  localparam int MW    = CH_W + addr_width;
  localparam logic [PW-1:0]   DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0]   AF_TH    = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0]   AE_TH    = PW'(AE_MARGIN);
  localparam logic [CH_W:0]   NUM_CH_P = (CH_W + 1)'(NUM_CH);

  logic [data_width-1:0] mem [NUM_CH*DEPTH];
  logic [PW-1:0] wptr [NUM_CH];
  logic [PW-1:0] rptr [NUM_CH];
  logic [PW-1:0] cnt  [NUM_CH];

  // Flags come purely from registered pointers, so they reflect the state
  // at the start of a cycle; there is no write-to-read bypass.
  always_comb begin
    FULL         = '0;
    EMPTY        = '0;
    ALMOST_FULL  = '0;
    ALMOST_EMPTY = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c]          = wptr[c] - rptr[c];
      EMPTY[c]        = (cnt[c] == '0);
      FULL[c]         = (cnt[c] == DEPTH_P);
      ALMOST_FULL[c]  = (cnt[c] >= AF_TH);
      ALMOST_EMPTY[c] = (cnt[c] <= AE_TH);
    end
  end

  // Request semantics: W_EN/R_EN are one-cycle requests with no back-pressure;
  // a request is accepted at the edge if its channel is in range and not
  // full/empty, otherwise it is dropped and flagged on OVF/UDF.
  logic              w_ch_ok, r_ch_ok, wr_ok, rd_ok;
  logic [CH_W-1:0]   w_err_ch, r_err_ch;
  logic [PW-1:0]     wptr_sel, rptr_sel;
  logic [MW-1:0]     waddr, raddr;
  logic [NUM_CH-1:0] ovf_set, udf_set;

  always_comb begin
    w_ch_ok  = ({1'b0, W_CH} < NUM_CH_P);
    r_ch_ok  = ({1'b0, R_CH} < NUM_CH_P);
    wr_ok    = W_EN && w_ch_ok && !FULL[W_CH];
    rd_ok    = R_EN && r_ch_ok && !EMPTY[R_CH];
    w_err_ch = w_ch_ok ? W_CH : '0;
    r_err_ch = r_ch_ok ? R_CH : '0;
    ovf_set  = (W_EN && !wr_ok) ? (NUM_CH'(1) << w_err_ch) : '0;
    udf_set  = (R_EN && !rd_ok) ? (NUM_CH'(1) << r_err_ch) : '0;
    wptr_sel = wptr[W_CH];
    rptr_sel = rptr[R_CH];
    waddr    = {W_CH, wptr_sel[addr_width-1:0]};
    raddr    = {R_CH, rptr_sel[addr_width-1:0]};
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (!RST && wr_ok) mem[waddr] <= W_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
      end
      R_DATA  <= '0;
      R_VALID <= 1'b0;
      OVF     <= '0;
      UDF     <= '0;
    end else begin
      if (wr_ok) wptr[W_CH] <= wptr_sel + PW'(1);
      if (rd_ok) begin
        rptr[R_CH] <= rptr_sel + PW'(1);
        R_DATA     <= mem[raddr];
      end
      R_VALID <= rd_ok;
`ifdef MC_FIFO_ERR_STICKY_EN
      // Set has priority over a same-cycle clear.
      OVF <= (OVF & ~ERR_CLR) | ovf_set;
      UDF <= (UDF & ~ERR_CLR) | udf_set;
`else
      OVF <= ovf_set;
      UDF <= udf_set;
`endif
    end
  end

`ifndef MC_FIFO_ERR_STICKY_EN
  logic unused_err_clr;
  assign unused_err_clr = ^ERR_CLR;
`endif

endmodule

// File: tb/tb_mc_sync_fifo.sv
// Directed bench for mc_sync_fifo: fill/drain, interleave, simultaneous r/w, wrap, reset.
// Sticky-error checks are enabled when MC_FIFO_ERR_STICKY_EN is defined.
module tb_mc_sync_fifo;
  localparam int AW  = 4;
  localparam int DW  = 9;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic           W_EN;
  logic [CHW-1:0] W_CH;
  logic [DW-1:0]  W_DATA;
  logic           R_EN;
  logic [CHW-1:0] R_CH;
  logic [DW-1:0]  R_DATA;
  logic           R_VALID;
  logic [NCH-1:0] FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVF, UDF, ERR_CLR;

  mc_sync_fifo #(
    .addr_width(AW), .data_width(DW), .NUM_CH(NCH), .AF_MARGIN(2), .AE_MARGIN(2)
  ) dut (
    .CLK(CLK), .RST(RST), .W_EN(W_EN), .W_CH(W_CH), .W_DATA(W_DATA),
    .R_EN(R_EN), .R_CH(R_CH), .R_DATA(R_DATA), .R_VALID(R_VALID),
    .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .OVF(OVF), .UDF(UDF), .ERR_CLR(ERR_CLR)
  );

  // clock
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // driver: apply one cycle of requests, sample #1 after the edge
  task automatic cyc(input logic we, input logic [CHW-1:0] wc, input logic [DW-1:0] wd,
                     input logic re, input logic [CHW-1:0] rc);
    W_EN = we; W_CH = wc; W_DATA = wd; R_EN = re; R_CH = rc;
    @(posedge CLK);
    #1;
    W_EN = 1'b0; R_EN = 1'b0; ERR_CLR = '0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [CHW-1:0] ch, input logic [DW-1:0] d);
    cyc(1'b1, ch, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [CHW-1:0] ch);
    cyc(1'b0, '0, '0, 1'b1, ch);
  endtask

  task automatic rd_check(input string tag);
    exp_d = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(R_VALID), 32'd1);
    chk({tag, "_data"}, 32'(R_DATA), 32'(exp_d));
  endtask

  // after an error event: pulse ends (or stays set if sticky) and clears
  task automatic after_err(input logic [NCH-1:0] ovf_e, input logic [NCH-1:0] udf_e);
    idle();
`ifdef MC_FIFO_ERR_STICKY_EN
    chk("err_hold_ovf", 32'(OVF), 32'(ovf_e));
    chk("err_hold_udf", 32'(UDF), 32'(udf_e));
    ERR_CLR = '1;
    idle();
`else
    chk("err_gone_ovf_ignored_exp", 32'(ovf_e & '0), 32'(OVF & '0) | 32'(OVF));
`endif
    chk("err_clear_ovf", 32'(OVF), 32'd0);
    chk("err_clear_udf", 32'(UDF), 32'd0);
  endtask

  initial begin
    RST = 1'b1; W_EN = 1'b0; W_CH = '0; W_DATA = '0;
    R_EN = 1'b0; R_CH = '0; ERR_CLR = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // reset state
    chk("rst_empty", 32'(EMPTY), 32'hF);
    chk("rst_full", 32'(FULL), 32'h0);
    chk("rst_ae", 32'(ALMOST_EMPTY), 32'hF);
    chk("rst_af", 32'(ALMOST_FULL), 32'h0);
    chk("rst_rvalid", 32'(R_VALID), 32'd0);
    chk("rst_rdata", 32'(R_DATA), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_udf", 32'(UDF), 32'd0);
    idle();
    chk("idle_rvalid", 32'(R_VALID), 32'd0);
    chk("idle_empty", 32'(EMPTY), 32'hF);

    // fill channel 2
    for (int i = 0; i < 16; i++) begin
      wr(2'd2, DW'(9'h100 + i));
      exp_q.push_back(DW'(9'h100 + i));
      chk("fill_af2", 32'(ALMOST_FULL[2]), 32'((i + 1) >= 14));
      chk("fill_full2", 32'(FULL[2]), 32'((i + 1) == 16));
      chk("fill_ae2", 32'(ALMOST_EMPTY[2]), 32'((i + 1) <= 2));
      chk("fill_empty", 32'(EMPTY), 32'hB);
    end
    wr(2'd2, 9'h1AA);
    chk("ovf2_pulse", 32'(OVF), 32'h4);
    chk("ovf2_full", 32'(FULL), 32'h4);
    chk("ovf2_empty", 32'(EMPTY), 32'hB);
    after_err(4'h4, 4'h0);

    // drain channel 2
    for (int i = 0; i < 16; i++) begin
      rd(2'd2);
      rd_check("drain2");
      chk("drain_full2", 32'(FULL[2]), 32'd0);
      chk("drain_empty2", 32'(EMPTY[2]), 32'(i == 15));
      chk("drain_ae2", 32'(ALMOST_EMPTY[2]), 32'((15 - i) <= 2));
    end
    rd(2'd2);
    chk("udf2_pulse", 32'(UDF), 32'h4);
    chk("udf2_rvalid", 32'(R_VALID), 32'd0);
    chk("udf2_hold", 32'(R_DATA), 32'h10F);
    after_err(4'h0, 4'h4);

    // interleaved channels
    wr(2'd0, 9'h011);
    wr(2'd1, 9'h022);
    wr(2'd0, 9'h033);
    chk("ilv_empty", 32'(EMPTY), 32'hC);
    rd(2'd1);
    chk("ilv_rd1", 32'(R_DATA), 32'h022);
    chk("ilv_v1", 32'(R_VALID), 32'd1);
    rd(2'd0);
    chk("ilv_rd2", 32'(R_DATA), 32'h011);
    rd(2'd0);
    chk("ilv_rd3", 32'(R_DATA), 32'h033);
    chk("ilv_empty_end", 32'(EMPTY), 32'hF);

    // simultaneous read/write on empty ch3
    cyc(1'b1, 2'd3, 9'h055, 1'b1, 2'd3);
    exp_q.push_back(9'h055);
    chk("sim_e_udf", 32'(UDF), 32'h8);
    chk("sim_e_rvalid", 32'(R_VALID), 32'd0);
    chk("sim_e_empty3", 32'(EMPTY[3]), 32'd0);
    chk("sim_e_ae3", 32'(ALMOST_EMPTY[3]), 32'd1);
    after_err(4'h0, 4'h8);
    for (int i = 0; i < 15; i++) begin
      wr(2'd3, DW'(9'h160 + i));
      exp_q.push_back(DW'(9'h160 + i));
    end
    chk("sim_f_full_before", 32'(FULL[3]), 32'd1);

    // simultaneous read/write on full ch3: read wins, write rejected
    cyc(1'b1, 2'd3, 9'h1EE, 1'b1, 2'd3);
    rd_check("sim_f");
    chk("sim_f_ovf", 32'(OVF), 32'h8);
    chk("sim_f_full_after", 32'(FULL[3]), 32'd0);
    chk("sim_f_af3", 32'(ALMOST_FULL[3]), 32'd1);
    after_err(4'h8, 4'h0);
    for (int i = 0; i < 15; i++) begin
      rd(2'd3);
      rd_check("drain3");
    end
    chk("drain3_empty", 32'(EMPTY[3]), 32'd1);

    // push/pop pairs across the pointer wrap
    wr(2'd3, 9'h005);
    exp_q.push_back(9'h005);
    for (int i = 1; i < 40; i++) begin
      cyc(1'b1, 2'd3, DW'(i * 37 + 5), 1'b1, 2'd3);
      exp_q.push_back(DW'(i * 37 + 5));
      rd_check("wrap");
      chk("wrap_empty3", 32'(EMPTY[3]), 32'd0);
    end
    rd(2'd3);
    rd_check("wrap_last");
    chk("wrap_done_empty", 32'(EMPTY), 32'hF);

`ifdef MC_FIFO_ERR_STICKY_EN
    // sticky OVF on ch1, then ERR_CLR
    for (int i = 0; i < 16; i++) wr(2'd1, DW'(i));
    wr(2'd1, 9'h1FF);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("sticky_ovf1", 32'(OVF), 32'h2);
    end
    ERR_CLR = 4'h2;
    idle();
    chk("sticky_clr", 32'(OVF), 32'h0);
`endif

    // reset during a read
    wr(2'd1, 9'h0AB);
    RST = 1'b1; R_EN = 1'b1; R_CH = 2'd1;
    @(posedge CLK);
    #1;
    RST = 1'b0; R_EN = 1'b0;
    chk("rstrd_rvalid", 32'(R_VALID), 32'd0);
    chk("rstrd_empty", 32'(EMPTY), 32'hF);
    chk("rstrd_udf", 32'(UDF), 32'd0);
    rd(2'd1);
    chk("rstrd_udf1", 32'(UDF), 32'h2);
    chk("rstrd_rv2", 32'(R_VALID), 32'd0);
    after_err(4'h0, 4'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
